// File: rtl/uart_pkg.sv
// Shared UART constants and the TX arbiter state encoding.
// Used by the RX/TX blocks and by uart_tx_arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO
  } arb_state_t;

  localparam int BYTE_W     = 8;
  localparam int CLK_HZ     = 50_000_000;
  localparam int BAUD       = 9600;
  localparam int BIT_CYCLES = 5208;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
// Scans ptr, ptr+1, ... mod N over req & mask.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam int SW = IW + 1;

  logic [N-1:0]  elig;
  logic [SW-1:0] s;
  logic [IW-1:0] j;

  assign elig = req_i & mask_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      // one extra bit so non-power-of-two N can wrap by compare
      s = {1'b0, ptr_i} + SW'(k);
      if (s >= SW'(N)) s = s - SW'(N);
      j = s[IW-1:0];
      if (!any_o && elig[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters,
// with message locking and busy/lock timeouts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = BYTE_W,
  parameter int BUSY_TO = 16,
  parameter int LOCK_TO = 1048576,
  parameter int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_busy_i,
  output logic                      grant_valid_o,
  output logic [IW-1:0]             grant_id_o,
  output logic                      err_timeout_o
);

  localparam int BW = $clog2(BUSY_TO + 1);
  localparam int LW = $clog2(LOCK_TO + 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TO - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TO - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic              gv_q, gv_d;
  logic              lock_q, lock_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  function automatic logic [IW-1:0] inc_id(input logic [IW-1:0] i);
    return (i == LAST_ID) ? '0 : i + 1'b1;
  endfunction

  assign owner_oh = N_REQ'(1) << gid_q;
  assign mask     = lock_q ? owner_oh : '1;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (rr_q),
    .mask_i (mask),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign req_ready_o   = (state_q == IDLE && !rst) ? pick_gnt : '0;
  assign tx_start_o    = (state_q == START);
  assign tx_data_o     = data_q;
  assign grant_valid_o = gv_q;
  assign grant_id_o    = gid_q;
  assign err_timeout_o = err_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    gv_d    = gv_q;
    lock_d  = lock_q;
    last_d  = last_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // when locked the mask leaves only the owner, so an owner
        // valid on the expiry cycle is accepted instead of aborting
        if (pick_any) begin
          data_d  = req_data_i[pick_idx*DATA_W +: DATA_W];
          gid_d   = pick_idx;
          last_d  = req_last_i[pick_idx];
          gv_d    = 1'b1;
          lcnt_d  = '0;
          state_d = START;
        end else if (lock_q) begin
          if (lcnt_q == LOCK_LAST) begin
            err_d  = 1'b1;
            lock_d = 1'b0;
            gv_d   = 1'b0;
            rr_d   = inc_id(gid_q);
            lcnt_d = '0;
          end else if (lcnt_q != '1) begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      START: begin
        bcnt_d  = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = WAIT_LO;
        end else if (bcnt_q == BUSY_LAST) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          gv_d    = 1'b0;
          rr_d    = inc_id(gid_q);
          state_d = IDLE;
        end else if (bcnt_q != '1) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy_i) begin
          state_d = IDLE;
          lcnt_d  = '0;
          if (last_q) begin
            lock_d = 1'b0;
            gv_d   = 1'b0;
            rr_d   = inc_id(gid_q);
          end else begin
            lock_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      gv_q    <= 1'b0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      gv_q    <= gv_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      err_q   <= err_d;
    end
  end

endmodule
